// File: rtl/uart_pkg.sv
// Shared definitions for the UART engine.
//   UART_DATA_W      : data bits per frame (8N1 format)
//   CLKS_PER_BIT_DEF : default clock cycles per serial bit (50 MHz / 115200)
//   tx_state_t       : transmit FSM states
//   rx_state_t       : receive FSM states
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int CLKS_PER_BIT_DEF = 434;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit
// boundary; restart holds the count at 0.
// Ports:
//   clk       : clock (rising edge)
//   rst_n     : asynchronous active-low reset
//   restart   : force the count back to 0 on the next edge
//   bit_done  : count is at the last cycle of a bit period
//   half_done : count is at the last cycle of the first half of a bit period
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_done,
    output logic half_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (restart || cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bit_done  = (cnt_reg == LAST);
    assign half_done = (cnt_reg == HALF);

endmodule

// File: rtl/uart_engine.sv
// 8N1 UART engine with independent transmitter and receiver.
// Ports:
//   clk_i        : clock (rising edge)
//   rst_ni       : asynchronous active-low reset
//   ctrl_i       : control-register image, bit0 = send request
//   tx_data_i    : byte to transmit, captured when a frame starts
//   clear_send_o : one-cycle pulse (TX DONE) clearing the send bit
//   set_new_o    : one-cycle pulse setting the new-data bit on a good frame
//   rx_data_o    : last correctly received byte
//   frame_err_o  : one-cycle pulse when the stop bit is sampled low
//   tx_busy_o    : transmitter is not idle
//   tx_o         : serial output, idle high
//   rx_i         : asynchronous serial input
module uart_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [31:0]            ctrl_i,
    input  logic [UART_DATA_W-1:0] tx_data_i,
    output logic                   clear_send_o,
    output logic                   set_new_o,
    output logic [UART_DATA_W-1:0] rx_data_o,
    output logic                   frame_err_o,
    output logic                   tx_busy_o,
    output logic                   tx_o,
    input  logic                   rx_i
);

    localparam int IDX_W = $clog2(UART_DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_W - 1);

    // Only the send bit of the control image matters here.
    logic ctrl_unused;
    assign ctrl_unused = ^ctrl_i[31:1];

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t              tx_state_reg, tx_state_next;
    logic [UART_DATA_W-1:0] tx_data_reg;
    logic [IDX_W-1:0]       tx_idx_reg;
    logic                   tx_bit_done;
    logic                   tx_half_unused;
    logic                   tx_restart;

    // Timer runs only while a bit is on the line; it is parked at 0 in
    // IDLE and DONE so START always gets a full bit period.
    assign tx_restart = (tx_state_reg == TX_IDLE) || (tx_state_reg == TX_DONE);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .restart   (tx_restart),
        .bit_done  (tx_bit_done),
        .half_done (tx_half_unused)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_reg <= TX_IDLE;
            tx_data_reg  <= '0;
            tx_idx_reg   <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            if (tx_state_reg == TX_IDLE && ctrl_i[0]) begin
                tx_data_reg <= tx_data_i;
            end
            if (tx_state_reg == TX_START) begin
                tx_idx_reg <= '0;
            end else if (tx_state_reg == TX_DATA && tx_bit_done) begin
                tx_idx_reg <= tx_idx_reg + 1'b1;
            end
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            TX_IDLE:  if (ctrl_i[0]) tx_state_next = TX_START;
            TX_START: if (tx_bit_done) tx_state_next = TX_DATA;
            TX_DATA:  if (tx_bit_done && tx_idx_reg == LAST_IDX) tx_state_next = TX_STOP;
            TX_STOP:  if (tx_bit_done) tx_state_next = TX_DONE;
            TX_DONE:  tx_state_next = TX_IDLE;
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_o = 1'b1;
        case (tx_state_reg)
            TX_START: tx_o = 1'b0;
            TX_DATA:  tx_o = tx_data_reg[tx_idx_reg];
            default:  tx_o = 1'b1;
        endcase
    end

    assign clear_send_o = (tx_state_reg == TX_DONE);
    assign tx_busy_o    = (tx_state_reg != TX_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    rx_state_t              rx_state_reg, rx_state_next;
    logic [1:0]             rx_sync_reg;
    logic                   rx_prev_reg;
    logic                   rx_s;
    logic [UART_DATA_W-1:0] rx_shift_reg;
    logic [IDX_W-1:0]       rx_idx_reg;
    logic [UART_DATA_W-1:0] rx_data_reg;
    logic                   set_new_reg;
    logic                   frame_err_reg;
    logic                   rx_bit_done;
    logic                   rx_half_done;
    logic                   rx_restart;

    assign rx_s = rx_sync_reg[1];

    // Restarting at the half-bit point of the start bit makes every later
    // bit_done land in the middle of a bit.
    assign rx_restart = (rx_state_reg == RX_IDLE) ||
                        (rx_state_reg == RX_START && rx_half_done);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .restart   (rx_restart),
        .bit_done  (rx_bit_done),
        .half_done (rx_half_done)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync_reg   <= 2'b11;
            rx_prev_reg   <= 1'b1;
            rx_state_reg  <= RX_IDLE;
            rx_shift_reg  <= '0;
            rx_idx_reg    <= '0;
            rx_data_reg   <= '0;
            set_new_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rx_sync_reg   <= {rx_sync_reg[0], rx_i};
            rx_prev_reg   <= rx_s;
            rx_state_reg  <= rx_state_next;
            set_new_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            if (rx_state_reg == RX_START && rx_half_done) begin
                rx_idx_reg <= '0;
            end
            if (rx_state_reg == RX_DATA && rx_bit_done) begin
                rx_shift_reg <= {rx_s, rx_shift_reg[UART_DATA_W-1:1]};
                rx_idx_reg   <= rx_idx_reg + 1'b1;
            end
            if (rx_state_reg == RX_STOP && rx_bit_done) begin
                if (rx_s) begin
                    rx_data_reg <= rx_shift_reg;
                    set_new_reg <= 1'b1;
                end else begin
                    frame_err_reg <= 1'b1;
                end
            end
        end
    end

    // The edge detector needs the line to have been high the cycle before,
    // so after a bad stop bit a new frame waits for the line to go high.
    always_comb begin
        rx_state_next = rx_state_reg;
        case (rx_state_reg)
            RX_IDLE:  if (rx_prev_reg && !rx_s) rx_state_next = RX_START;
            RX_START: if (rx_half_done) rx_state_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_done && rx_idx_reg == LAST_IDX) rx_state_next = RX_STOP;
            RX_STOP:  if (rx_bit_done) rx_state_next = RX_IDLE;
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    assign rx_data_o   = rx_data_reg;
    assign set_new_o   = set_new_reg;
    assign frame_err_o = frame_err_reg;

endmodule

// File: tb/tb_uart_engine.sv
module tb_uart_engine;

    localparam int N = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] ctrl_i;
    logic [7:0]  tx_data_i;
    logic        clear_send_o;
    logic        set_new_o;
    logic [7:0]  rx_data_o;
    logic        frame_err_o;
    logic        tx_busy_o;
    logic        tx_o;
    logic        rx_i;

    uart_engine #(.CLKS_PER_BIT(N)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ctrl_i       (ctrl_i),
        .tx_data_i    (tx_data_i),
        .clear_send_o (clear_send_o),
        .set_new_o    (set_new_o),
        .rx_data_o    (rx_data_o),
        .frame_err_o  (frame_err_o),
        .tx_busy_o    (tx_busy_o),
        .tx_o         (tx_o),
        .rx_i         (rx_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboards
    typedef struct packed { logic [7:0] data; logic abort; } tx_exp_t;
    typedef struct packed { logic [7:0] data; logic is_err; } rx_exp_t;
    tx_exp_t tx_q[$];
    rx_exp_t rx_q[$];

    // TX monitor: expected line image of a frame is {stop, data, start},
    // each bit N cycles, with clear_send exactly 10*N cycles after start.
    logic       tx_active = 1'b0;
    int         tx_pos = 0;
    logic [9:0] tx_frame;
    logic       tx_cur_abort;
    logic [7:0] tx_cur_data;

    always @(negedge clk_i) begin
        tx_exp_t e;
        if (!rst_ni) begin
            if (tx_active) begin
                check("tx_abort_expected", {31'd0, tx_cur_abort}, 32'd1);
                tx_active = 1'b0;
            end
            check("tx_idle_in_reset", {31'd0, tx_o}, 32'd1);
            check("busy_in_reset", {31'd0, tx_busy_o}, 32'd0);
            if (clear_send_o) check("clear_send_in_reset", {31'd0, clear_send_o}, 32'd0);
        end else if (!tx_active) begin
            if (clear_send_o) check("clear_send_unexpected", {31'd0, clear_send_o}, 32'd0);
            if (tx_o == 1'b0) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected_start", {31'd0, tx_o}, 32'd1);
                end else begin
                    e = tx_q.pop_front();
                    tx_frame     = {1'b1, e.data, 1'b0};
                    tx_cur_abort = e.abort;
                    tx_cur_data  = e.data;
                    tx_active    = 1'b1;
                    check("tx_bit", {31'd0, tx_o}, {31'd0, tx_frame[0]});
                    check("busy_at_start", {31'd0, tx_busy_o}, 32'd1);
                    tx_pos = 1;
                end
            end
        end else begin
            if (tx_pos < 10 * N) begin
                check("tx_bit", {31'd0, tx_o}, {31'd0, tx_frame[tx_pos / N]});
                if (clear_send_o) check("clear_send_early", {31'd0, clear_send_o}, 32'd0);
                tx_pos++;
            end else begin
                check("clear_send_at_40", {31'd0, clear_send_o}, 32'd1);
                check("busy_in_done", {31'd0, tx_busy_o}, 32'd1);
                check("tx_not_aborted", {31'd0, tx_cur_abort}, 32'd0);
                $display("TX frame data=%02h done", tx_cur_data);
                tx_active = 1'b0;
            end
        end
    end

    // RX monitor: the model keeps the last good byte; rx_data_o must equal it.
    logic [7:0] rx_last = 8'h00;

    always @(negedge clk_i) begin
        rx_exp_t e;
        if (!rst_ni) begin
            rx_last = 8'h00;
            if (set_new_o) check("set_new_in_reset", {31'd0, set_new_o}, 32'd0);
            if (frame_err_o) check("frame_err_in_reset", {31'd0, frame_err_o}, 32'd0);
        end else begin
            if (set_new_o) begin
                if (rx_q.size() == 0 || rx_q[0].is_err) begin
                    check("set_new_unexpected", {31'd0, set_new_o}, 32'd0);
                    if (rx_q.size() != 0) void'(rx_q.pop_front());
                end else begin
                    e = rx_q.pop_front();
                    check("rx_data", {24'd0, rx_data_o}, {24'd0, e.data});
                    rx_last = e.data;
                    $display("RX frame data=%02h received=%02h", e.data, rx_data_o);
                end
            end
            if (frame_err_o) begin
                if (rx_q.size() == 0 || !rx_q[0].is_err) begin
                    check("frame_err_unexpected", {31'd0, frame_err_o}, 32'd0);
                    if (rx_q.size() != 0) void'(rx_q.pop_front());
                end else begin
                    e = rx_q.pop_front();
                    $display("RX frame data=%02h framing error", e.data);
                end
            end
            check("rx_data_hold", {24'd0, rx_data_o}, {24'd0, rx_last});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic wait_clear();
        int n = 0;
        while (!clear_send_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!clear_send_o) check("tx_done_timeout", {31'd0, clear_send_o}, 32'd1);
    endtask

    task automatic tx_send(input logic [7:0] data, input bit scramble);
        @(posedge clk_i); #1;
        tx_data_i = data;
        ctrl_i    = $urandom() | 32'h1;
        tx_q.push_back('{data: data, abort: 1'b0});
        if (scramble) begin
            repeat (8) @(posedge clk_i); #1;
            ctrl_i[0] = 1'b0;
            tx_data_i = ~data;
            repeat (12) @(posedge clk_i); #1;
            ctrl_i[0] = 1'b1;
            tx_data_i = 8'($urandom());
        end
        wait_clear();
        @(posedge clk_i); #1;
        ctrl_i[0] = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] data, input logic stop);
        logic [9:0] fb;
        fb = {stop, data, 1'b0};
        rx_q.push_back('{data: data, is_err: !stop});
        @(posedge clk_i); #1;
        for (int b = 0; b < 10; b++) begin
            rx_i = fb[b];
            repeat (N) @(posedge clk_i);
            #1;
        end
        rx_i = 1'b1;
        repeat (3 * N) @(posedge clk_i);
    endtask

    initial begin
        logic [7:0] a, b;
        int n;
        rst_ni    = 1'b0;
        ctrl_i    = 32'd0;
        tx_data_i = 8'd0;
        rx_i      = 1'b1;

        repeat (3) @(negedge clk_i);
        check("reset_tx_o", {31'd0, tx_o}, 32'd1);
        check("reset_busy", {31'd0, tx_busy_o}, 32'd0);
        check("reset_clear_send", {31'd0, clear_send_o}, 32'd0);
        check("reset_set_new", {31'd0, set_new_o}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err_o}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);

        // Directed frames
        tx_send(8'hA5, 1'b0);
        rx_frame(8'h3C, 1'b1);
        rx_frame(8'h55, 1'b0);
        @(posedge clk_i); #1;
        rx_i = 1'b0;
        @(posedge clk_i); #1;
        rx_i = 1'b1;
        repeat (3 * N) @(posedge clk_i);
        rx_frame(8'h81, 1'b1);

        // Randomized concurrent traffic
        for (int i = 0; i < 6; i++) begin
            a = 8'($urandom());
            b = 8'($urandom());
            fork
                tx_send(a, bit'($urandom_range(0, 1)));
                rx_frame(b, $urandom_range(0, 3) != 0);
            join
        end

        // Send bit left set through DONE starts a second frame
        a = 8'($urandom());
        b = 8'($urandom());
        @(posedge clk_i); #1;
        tx_data_i = a;
        ctrl_i    = 32'h1;
        tx_q.push_back('{data: a, abort: 1'b0});
        wait_clear();
        @(posedge clk_i); #1;
        tx_data_i = b;
        tx_q.push_back('{data: b, abort: 1'b0});
        wait_clear();
        @(posedge clk_i); #1;
        ctrl_i[0] = 1'b0;
        repeat (4) @(posedge clk_i);

        // Reset during data bit 3, then a full frame after release
        @(posedge clk_i); #1;
        tx_data_i = 8'h6B;
        ctrl_i    = 32'h1;
        tx_q.push_back('{data: 8'h6B, abort: 1'b1});
        n = 0;
        while (tx_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (tx_o) check("tx_start_timeout", {31'd0, tx_o}, 32'd0);
        repeat (17) @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        tx_data_i = 8'hC4;
        tx_q.push_back('{data: 8'hC4, abort: 1'b0});
        repeat (3) @(posedge clk_i); #1;
        rst_ni = 1'b1;
        wait_clear();
        @(posedge clk_i); #1;
        ctrl_i[0] = 1'b0;

        // Simultaneous TX of FF and RX of 00
        fork
            tx_send(8'hFF, 1'b0);
            rx_frame(8'h00, 1'b1);
        join

        repeat (5 * N) @(negedge clk_i);
        check("tx_queue_empty", tx_q.size(), 32'd0);
        check("rx_queue_empty", rx_q.size(), 32'd0);
        check("tx_frame_finished", {31'd0, tx_active}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_engine.md
UART_ENGINE -- requirements
Module: uart_engine

Interface
REQ-001 The block SHALL take parameter CLKS_PER_BIT, default 434 (50 MHz / 115200), as the clock cycles per serial bit, with a legal minimum of 4.
REQ-002 The block SHALL provide port clk_i, input, 1 bit, the single clock; all flops SHALL be on its rising edge.
REQ-003 The block SHALL provide port rst_ni, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL provide port ctrl_i, input, 32 bits, the control-register image; bit0 = send request, other bits ignored.
REQ-005 The block SHALL provide port tx_data_i, input, 8 bits, the byte to transmit, sampled at frame start.
REQ-006 The block SHALL provide port clear_send_o, output, 1 bit, a one-cycle pulse that clears the control-register send bit.
REQ-007 The block SHALL provide port set_new_o, output, 1 bit, a one-cycle pulse that sets the control-register new-data bit.
REQ-008 The block SHALL provide port rx_data_o, output, 8 bits, the last correctly received byte, held until the next valid frame.
REQ-009 The block SHALL provide port frame_err_o, output, 1 bit, a one-cycle pulse on a stop-bit error.
REQ-010 The block SHALL provide port tx_busy_o, output, 1 bit, high whenever the TX FSM is not IDLE.
REQ-011 The block SHALL provide port tx_o, output, 1 bit, the serial line out, idle high.
REQ-012 The block SHALL provide port rx_i, input, 1 bit, the asynchronous serial line in.

Function
REQ-013 The frame format SHALL be 8N1: start 0, 8 data bits LSB first, stop 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-014 TX FSM states SHALL be IDLE, START, DATA, STOP, DONE.
REQ-015 In IDLE, a cycle with ctrl_i[0]=1 SHALL latch tx_data_i and move to START; tx_o SHALL go low on the next cycle.
REQ-016 DATA SHALL shift out 8 bits via a 3-bit index; STOP SHALL drive 1 for CLKS_PER_BIT cycles, then go to DONE.
REQ-017 DONE SHALL last one cycle, assert clear_send_o combinationally during it, then return to IDLE.
REQ-018 A new frame SHALL NOT start earlier than the cycle after DONE.
REQ-019 ctrl_i[0] changes during a frame SHALL be ignored; ctrl_i[0] still 1 in IDLE after DONE (CPU rewrite) SHALL start a new frame.
REQ-020 rx_i SHALL pass through a 2-flop synchronizer before use.
REQ-021 RX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-022 A falling edge in IDLE SHALL enter START; at CLKS_PER_BIT/2 the line SHALL be resampled: 1 -> IDLE (glitch, no outputs), 0 -> DATA.
REQ-023 DATA SHALL sample 8 bits at mid-bit, every CLKS_PER_BIT cycles, LSB first.
REQ-024 STOP SHALL sample at mid-bit. If 1: update rx_data_o and pulse set_new_o for one cycle. If 0: pulse frame_err_o, leave rx_data_o unchanged, no set_new_o.
REQ-025 After STOP, RX SHALL return to IDLE and wait for line high before accepting a new falling edge.
REQ-026 TX and RX SHALL be fully independent; simultaneous clear_send_o and set_new_o pulses are legal.
REQ-027 Bit counters SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.

Reset
REQ-028 While rst_ni=0, both FSMs SHALL be IDLE, tx_o=1, synchronizer flops=1, rx_data_o=0, and all pulses, tx_busy_o and counters 0.
REQ-029 A reset mid-frame SHALL abort the frame immediately with no clear_send_o, set_new_o or frame_err_o.
REQ-030 After reset release, the first IDLE cycle with ctrl_i[0]=1 SHALL start a frame.

Structure
REQ-031 Package uart_pkg SHALL hold tx_state_t, rx_state_t, UART_DATA_W=8 and CLKS_PER_BIT_DEF=434.
REQ-032 Sub-module uart_bit_timer (counter plus bit_done/half_done strobes, restart input) SHALL be instantiated once each in TX and RX; no other sub-modules.

Verification
REQ-033 CLKS_PER_BIT=4, ctrl_i[0]=1, tx_data_i=8'hA5 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; one clear_send_o pulse 40 cycles after start.
REQ-034 rx_i driven with frame 8'h3C, valid stop -> rx_data_o=8'h3C, set_new_o high exactly 1 cycle, frame_err_o stays 0.
REQ-035 rx_i frame 8'h55 with stop=0 -> frame_err_o one pulse, no set_new_o, rx_data_o keeps its previous value.
REQ-036 rx_i low pulse of 1 cycle (glitch) -> RX returns to IDLE, no pulses; a following valid 8'h81 frame is received correctly.
REQ-037 rst_ni asserted mid-TX at data bit 3 -> tx_o=1 at once, no clear_send_o; after release, ctrl_i[0]=1 -> a full frame transmits.
REQ-038 TX of 8'hFF concurrent with RX of 8'h00 -> both complete; clear_send_o and set_new_o are each single pulses with correct data.
